// File: rtl/rd_skew_control_pkg.sv
// Shared definitions for the read-side skew controller: FSM encoding and default sizing.
package rd_skew_control_pkg;

    localparam int DEF_WIDTH_HEIGHT = 16;
    localparam int DEF_ADDR_W       = 8;
    // Extra step-counter bits so L + WIDTH_HEIGHT - 2 never overflows.
    localparam int STEP_PAD         = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rd_skew_control_if.sv
// Sequencer-side and memory-side signals of the read skew controller bundled as one port.
interface rd_skew_control_if
    import rd_skew_control_pkg::*;
#(
    parameter int WIDTH_HEIGHT = DEF_WIDTH_HEIGHT,
    parameter int ADDR_W       = DEF_ADDR_W
);

    logic                           start;
    logic [ADDR_W-1:0]              base_addr;
    logic [ADDR_W-1:0]              tile_rows;
    logic                           hold;
    logic                           busy;
    logic                           done;
    logic [WIDTH_HEIGHT-1:0]        rd_en;
    logic [WIDTH_HEIGHT*ADDR_W-1:0] rd_addr;

    modport master (
        output start, base_addr, tile_rows, hold,
        input  busy, done, rd_en, rd_addr
    );

    modport slave (
        input  start, base_addr, tile_rows, hold,
        output busy, done, rd_en, rd_addr
    );

endinterface

// File: rtl/rd_skew_control_lane.sv
// One memory lane: window compare and address offset for step t, delayed by LANE steps.
module rd_skew_control_lane
    import rd_skew_control_pkg::*;
#(
    parameter int LANE   = 0,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int STEP_W = DEF_ADDR_W + STEP_PAD
) (
    input  logic [STEP_W-1:0] t,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] len,
    output logic              en,
    output logic [ADDR_W-1:0] addr
);

    logic [STEP_W-1:0] offset;

    always_comb begin
        offset = t - STEP_W'(LANE);
        en     = (t >= STEP_W'(LANE)) && (offset < STEP_W'(len));
        // Row addresses wrap modulo 2^ADDR_W by truncating the offset.
        addr   = en ? base + offset[ADDR_W-1:0] : '0;
    end

endmodule

// File: rtl/rd_skew_control.sv
// Read skew controller: FSM and step counter issuing diagonally staggered per-lane reads.
module rd_skew_control
    import rd_skew_control_pkg::*;
#(
    parameter int WIDTH_HEIGHT = DEF_WIDTH_HEIGHT,
    parameter int ADDR_W       = DEF_ADDR_W
) (
    input  logic             clk,
    input  logic             reset,
    rd_skew_control_if.slave bus
);

    localparam int                STEP_W   = ADDR_W + STEP_PAD;
    localparam logic [STEP_W-1:0] LAST_OFS = STEP_W'(WIDTH_HEIGHT - 2);

    state_t                         state_q, state_d;
    logic [STEP_W-1:0]              t_q, t_d;
    logic [ADDR_W-1:0]              base_q, base_d;
    logic [ADDR_W-1:0]              len_q, len_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic [WIDTH_HEIGHT-1:0]        rd_en_q, rd_en_d, lane_en;
    logic [WIDTH_HEIGHT*ADDR_W-1:0] rd_addr_q, rd_addr_d, lane_addr;

    for (genvar i = 0; i < WIDTH_HEIGHT; i++) begin : g_lane
        rd_skew_control_lane #(
            .LANE   (i),
            .ADDR_W (ADDR_W),
            .STEP_W (STEP_W)
        ) u_lane (
            .t    (t_q),
            .base (base_q),
            .len  (len_q),
            .en   (lane_en[i]),
            .addr (lane_addr[i*ADDR_W +: ADDR_W])
        );
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
        state_d   = state_q;
        t_d       = t_q;
        base_d    = base_q;
        len_d     = len_q;
        // Outputs register the state of the cycle just ending, giving one cycle of latency.
        busy_d    = (state_q != IDLE);
        done_d    = (state_q == DONE);
        rd_en_d   = '0;
        rd_addr_d = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    base_d  = bus.base_addr;
                    len_d   = bus.tile_rows;
                    t_d     = '0;
                    state_d = (bus.tile_rows == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (bus.hold) begin
                    rd_addr_d = rd_addr_q;
                end else begin
                    rd_en_d   = lane_en;
                    rd_addr_d = lane_addr;
                    if (t_q == STEP_W'(len_q) + LAST_OFS) begin
                        state_d = DONE;
                    end else begin
                        t_d = t_q + STEP_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            t_q       <= '0;
            base_q    <= '0;
            len_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= '0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            base_q    <= base_d;
            len_q     <= len_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rd_en   = rd_en_q;
    assign bus.rd_addr = rd_addr_q;

endmodule
